// File: rtl/spi_pkg.sv
// SPI slave shared definitions: FSM state encoding
// and default frame/synchronizer parameters.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SHIFT        = 2'd1,
    DONE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } spi_state_e;

  localparam int SPI_WIDTH_DEF       = 32;
  localparam int SPI_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync.sv
// One-bit synchronizer chain plus an edge-detect register
// giving single-cycle rise/fall pulses.
module spi_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic CLK50MHZ,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_d, sync_q;
  logic              prev_d, prev_q;

  // shift the pin through the chain; remember last synced level
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  // synchronizer and edge-detect registers, idle level on reset
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, oversampled by CLK50MHZ.
// Define SPI_SLAVE_FRAME_ERR_EN to add frame_err/err_cnt.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH_DEF,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic             spi_sck,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rx_valid,
  output logic             busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic             frame_err,
  output logic [7:0]       err_cnt
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sck (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .d(spi_sck),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .d(spi_cs),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .d(spi_mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_state_e       state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [CW-1:0]    bit_cnt_d, bit_cnt_q;
  logic [WIDTH-1:0] data_out_d, data_out_q;
  logic             rx_valid_d, rx_valid_q;
  logic             miso_d, miso_q;
  logic [SW-1:0]    settle_d, settle_q;
  logic             armed_d, armed_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic             frame_err_d, frame_err_q;
  logic [7:0]       err_cnt_d, err_cnt_q;
`endif

  // arm frame start only once cs is seen high after the
  // reset-value flush of the synchronizer has completed
  always_comb begin
    settle_d = settle_q;
    if (settle_q != SW'(SYNC_STAGES)) begin
      settle_d = settle_q + SW'(1);
    end
    armed_d = armed_q |
              ((settle_q == SW'(SYNC_STAGES)) & cs_q);
  end

  // frame FSM next-state and datapath
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    data_out_d = data_out_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall && armed_q) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
          miso_d    = data_in[WIDTH-1];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CW'(WIDTH)) begin
          data_out_d = shreg_q;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          state_d    = DONE;
        end else if (cs_rise) begin
          miso_d  = 1'b0;
          state_d = IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
`endif
        end else if (sck_rise) begin
          shreg_d   = {shreg_q[WIDTH-2:0], mosi_q};
          bit_cnt_d = bit_cnt_q + CW'(1);
        end else if (sck_fall) begin
          miso_d = shreg_q[WIDTH-1];
        end
      end
      DONE: begin
        miso_d  = 1'b0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        miso_d = 1'b0;
        if (cs_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      data_out_q <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out_q <= data_out_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign spi_miso = miso_q;
  assign data_out = data_out_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
